// File: rtl/cv32e40p_rf_writeback.sv
// rtl/cv32e40p_rf_writeback.sv - register file write-back arbiter
// One buffered result per producer; up to two commits per cycle; pending-write scoreboard.
module cv32e40p_rf_writeback #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SRC    = 3,
    parameter int FPU        = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_SRC-1:0]                   src_valid_i,
    output logic [NUM_SRC-1:0]                   src_ready_o,
    input  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0]   src_addr_i,
    input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]   src_data_i,
    output logic [ADDR_WIDTH-1:0]                waddr_a_o,
    output logic [DATA_WIDTH-1:0]                wdata_a_o,
    output logic                                 we_a_o,
    output logic [ADDR_WIDTH-1:0]                waddr_b_o,
    output logic [DATA_WIDTH-1:0]                wdata_b_o,
    output logic                                 we_b_o,
    output logic [2**ADDR_WIDTH-1:0]             busy_o,
    output logic                                 err_o
);

    logic [NUM_SRC-1:0]                 buf_valid;
    logic [NUM_SRC-1:0][ADDR_WIDTH-1:0] buf_addr;
    logic [NUM_SRC-1:0][DATA_WIDTH-1:0] buf_data;
    logic [NUM_SRC-1:0]                 commit;
    logic [NUM_SRC-1:0]                 accept;
    logic [NUM_SRC-1:0]                 drop_zero;
    logic [NUM_SRC-1:0]                 drop_fp;

    // Port B takes the highest-priority buffer; port A the next one with a different address,
    // so same-register writes retire strictly in producer-index order.
    always_comb begin
        commit    = '0;
        we_b_o    = 1'b0;
        waddr_b_o = '0;
        wdata_b_o = '0;
        we_a_o    = 1'b0;
        waddr_a_o = '0;
        wdata_a_o = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (buf_valid[s]) begin
                if (!we_b_o) begin
                    we_b_o    = 1'b1;
                    waddr_b_o = buf_addr[s];
                    wdata_b_o = buf_data[s];
                    commit[s] = 1'b1;
                end else if (!we_a_o && (buf_addr[s] != waddr_b_o)) begin
                    we_a_o    = 1'b1;
                    waddr_a_o = buf_addr[s];
                    wdata_a_o = buf_data[s];
                    commit[s] = 1'b1;
                end
            end
        end
    end

    assign src_ready_o = ~buf_valid | commit;
    assign accept      = src_valid_i & src_ready_o;

    always_comb begin
        drop_zero = '0;
        drop_fp   = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            drop_zero[s] = (src_addr_i[s] == '0);
            drop_fp[s]   = (FPU == 0) && src_addr_i[s][ADDR_WIDTH-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid <= '0;
            buf_addr  <= '0;
            buf_data  <= '0;
            err_o     <= 1'b0;
        end else begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (accept[s] && !drop_zero[s] && !drop_fp[s]) begin
                    buf_valid[s] <= 1'b1;
                    buf_addr[s]  <= src_addr_i[s];
                    buf_data[s]  <= src_data_i[s];
                end else if (commit[s]) begin
                    buf_valid[s] <= 1'b0;
                end
            end
            err_o <= |(accept & drop_fp);
        end
    end

    always_comb begin
        busy_o = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (buf_valid[s]) begin
                busy_o[buf_addr[s]] = 1'b1;
            end
        end
        busy_o[0] = 1'b0;
    end

endmodule

// File: tb/tb_cv32e40p_rf_writeback.sv
// tb/tb_cv32e40p_rf_writeback.sv - scoreboard bench for cv32e40p_rf_writeback
// Stimulus pushes expected commits; a negedge monitor pops them as the write ports fire.
module tb_cv32e40p_rf_writeback;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       src_valid;
    logic [2:0]       src_ready;
    logic [2:0][5:0]  src_addr;
    logic [2:0][31:0] src_data;
    logic [5:0]       waddr_a, waddr_b;
    logic [31:0]      wdata_a, wdata_b;
    logic             we_a, we_b;
    logic [63:0]      busy;
    logic             err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        port_b;
        logic [5:0]  addr;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    cv32e40p_rf_writeback #(
        .ADDR_WIDTH(6), .DATA_WIDTH(32), .NUM_SRC(3), .FPU(0)
    ) dut (
        .clk(clk), .rst(rst),
        .src_valid_i(src_valid), .src_ready_o(src_ready),
        .src_addr_i(src_addr), .src_data_i(src_data),
        .waddr_a_o(waddr_a), .wdata_a_o(wdata_a), .we_a_o(we_a),
        .waddr_b_o(waddr_b), .wdata_b_o(wdata_b), .we_b_o(we_b),
        .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] v,
                         input logic [5:0] a0, input logic [5:0] a1, input logic [5:0] a2,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        src_valid = v;
        src_addr  = {a2, a1, a0};
        src_data  = {d2, d1, d0};
    endtask

    task automatic expect_wr(input logic port_b, input logic [5:0] a, input logic [31:0] d);
        exp_t e;
        e.port_b = port_b;
        e.addr   = a;
        e.data   = d;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input logic port_b, input logic [5:0] a, input logic [31:0] d);
        exp_t e;
        exp_t got;
        got.port_b = port_b;
        got.addr   = a;
        got.data   = d;
        if (exp_q.size() == 0) begin
            check("unexpected_write", {25'd0, got}, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check("commit", {25'd0, got}, {25'd0, e});
        end
    endtask

    // Monitor: port B is popped before port A within a cycle, matching push order.
    always @(negedge clk) begin
        if (we_b) begin
            check("wb_addr_nonzero", {63'd0, waddr_b != 6'd0}, 64'd1);
            pop_cmp(1'b1, waddr_b, wdata_b);
        end
        if (we_a) begin
            check("wa_addr_nonzero", {63'd0, waddr_a != 6'd0}, 64'd1);
            pop_cmp(1'b0, waddr_a, wdata_a);
        end
        if (we_a && we_b) begin
            check("ports_distinct_addr", {63'd0, waddr_a != waddr_b}, 64'd1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(3'b111, 6'd1, 6'd2, 6'd3, 32'h1, 32'h2, 32'h3);
        tick();
        tick();
        check("rst_we_a", {63'd0, we_a}, 64'd0);
        check("rst_we_b", {63'd0, we_b}, 64'd0);
        check("rst_busy", busy, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        rst = 1'b0;
        drive(3'b000, 6'd0, 6'd0, 6'd0, 32'h0, 32'h0, 32'h0);
        check("rst_ready", {61'd0, src_ready}, 64'd7);
        tick();

        // Single write
        drive(3'b001, 6'd5, 6'd0, 6'd0, 32'hDEADBEEF, 32'h0, 32'h0);
        expect_wr(1'b1, 6'd5, 32'hDEADBEEF);
        tick();
        drive(3'b000, 6'd0, 6'd0, 6'd0, 32'h0, 32'h0, 32'h0);
        check("single_busy5_set", {63'd0, busy[5]}, 64'd1);
        check("single_we_a", {63'd0, we_a}, 64'd0);
        tick();
        check("single_busy5_clr", {63'd0, busy[5]}, 64'd0);

        // Dual issue with a held third producer
        drive(3'b111, 6'd3, 6'd7, 6'd9, 32'h11, 32'h22, 32'h33);
        expect_wr(1'b1, 6'd3, 32'h11);
        expect_wr(1'b0, 6'd7, 32'h22);
        expect_wr(1'b1, 6'd9, 32'h33);
        tick();
        drive(3'b000, 6'd0, 6'd0, 6'd0, 32'h0, 32'h0, 32'h0);
        check("dual_ready_held", {61'd0, src_ready}, 64'd3);
        check("dual_busy", busy, (64'd1 << 3) | (64'd1 << 7) | (64'd1 << 9));
        tick();
        check("dual_ready_after", {61'd0, src_ready}, 64'd7);
        check("dual_busy_9", busy, 64'd1 << 9);
        tick();
        check("dual_busy_idle", busy, 64'd0);

        // Same-address conflict
        drive(3'b011, 6'd4, 6'd4, 6'd0, 32'hAA, 32'hBB, 32'h0);
        expect_wr(1'b1, 6'd4, 32'hAA);
        expect_wr(1'b1, 6'd4, 32'hBB);
        tick();
        drive(3'b000, 6'd0, 6'd0, 6'd0, 32'h0, 32'h0, 32'h0);
        check("conf_we_a", {63'd0, we_a}, 64'd0);
        check("conf_busy4_c1", {63'd0, busy[4]}, 64'd1);
        tick();
        check("conf_busy4_c2", {63'd0, busy[4]}, 64'd1);
        tick();
        check("conf_busy4_clr", {63'd0, busy[4]}, 64'd0);

        // Back-to-back accepts on one producer (commit and refill in the same cycle)
        drive(3'b001, 6'd10, 6'd0, 6'd0, 32'h1, 32'h0, 32'h0);
        expect_wr(1'b1, 6'd10, 32'h1);
        expect_wr(1'b1, 6'd11, 32'h2);
        tick();
        drive(3'b001, 6'd11, 6'd0, 6'd0, 32'h2, 32'h0, 32'h0);
        check("tput_ready0", {63'd0, src_ready[0]}, 64'd1);
        tick();
        drive(3'b000, 6'd0, 6'd0, 6'd0, 32'h0, 32'h0, 32'h0);
        check("tput_busy11", busy, 64'd1 << 11);
        tick();

        // Address-zero drop
        drive(3'b010, 6'd0, 6'd0, 6'd0, 32'h0, 32'h55, 32'h0);
        check("zero_ready1", {63'd0, src_ready[1]}, 64'd1);
        tick();
        drive(3'b000, 6'd0, 6'd0, 6'd0, 32'h0, 32'h0, 32'h0);
        check("zero_we", {62'd0, we_a, we_b}, 64'd0);
        check("zero_busy", busy, 64'd0);
        check("zero_err", {63'd0, err}, 64'd0);
        tick();

        // Illegal FP-bank write
        drive(3'b001, 6'h21, 6'd0, 6'd0, 32'h77, 32'h0, 32'h0);
        check("fp_ready0", {63'd0, src_ready[0]}, 64'd1);
        tick();
        drive(3'b000, 6'd0, 6'd0, 6'd0, 32'h0, 32'h0, 32'h0);
        check("fp_err_pulse", {63'd0, err}, 64'd1);
        check("fp_we", {62'd0, we_a, we_b}, 64'd0);
        check("fp_busy", busy, 64'd0);
        tick();
        check("fp_err_clr", {63'd0, err}, 64'd0);

        // Mid-operation asynchronous reset: buffered writes must never commit
        drive(3'b111, 6'd12, 6'd13, 6'd14, 32'hC, 32'hD, 32'hE);
        tick();
        drive(3'b000, 6'd0, 6'd0, 6'd0, 32'h0, 32'h0, 32'h0);
        check("mid_we_b_before", {63'd0, we_b}, 64'd1);
        check("mid_busy_before", busy, (64'd1 << 12) | (64'd1 << 13) | (64'd1 << 14));
        #1;
        rst = 1'b1;
        #1;
        check("mid_we_async", {62'd0, we_a, we_b}, 64'd0);
        check("mid_busy_async", busy, 64'd0);
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check("mid_busy_after", busy, 64'd0);

        check("queue_drained", exp_q.size(), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
